// File: rtl/gen_gamma_pkg.sv
// Shared constants and helpers for the gamma decoder and its output FIFO.
package gen_gamma_pkg;

    localparam int         SIZE_DEFAULT  = 8;
    localparam int         DEPTH_DEFAULT = 4;
    localparam logic [7:0] ERR_CNT_MAX   = 8'd255;

    // Saturating increment of the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt, input logic en);
        logic [7:0] res;
        if (en && (cnt != ERR_CNT_MAX)) begin
            res = cnt + 8'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/gamma_fifo.sv
// Synchronous RAM-style FIFO with wrap-bit pointers and a registered level.
// Pushes when full and pops when empty are ignored.
module gamma_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;
    logic             empty_s;

    // Full/empty from the wrap-bit pointer pair, then qualified push/pop.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_push_s = push & ~full_s;
        do_pop_s  = pop & ~empty_s;
    end

    // Pointers advance modulo 2*DEPTH on qualified push/pop.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            level_r <= {PW{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low clear.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled; clear to zero on reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gen_gamma_decoder.sv
// Gamma decoder: registers a coded word and its gamma, subtracts the gamma,
// flags inconsistent words and queues {err, data} into a small output FIFO.
module gen_gamma_decoder
    import gen_gamma_pkg::*;
#(
    parameter  int SIZE  = SIZE_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE:0]   in_coded,
    input  logic [SIZE-1:0] in_gamma,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_err,
    output logic [LW-1:0]   level,
    output logic [7:0]      err_cnt
);

    // Entry width follows SIZE, so the entry type lives here rather than in the package.
    typedef struct packed {
        logic            err;
        logic [SIZE-1:0] data;
    } fifo_entry_t;

    localparam logic [LW:0] DEPTH_W = (LW + 1)'(DEPTH);

    logic            accept_s;
    logic            pop_s;
    logic [SIZE:0]   coded_r;
    logic [SIZE-1:0] gamma_r;
    logic            s_vld_r;
    logic [SIZE+1:0] diff_s;
    fifo_entry_t     wr_entry_s;
    fifo_entry_t     rd_entry_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [LW-1:0]   fifo_level_s;
    logic [LW:0]     occupancy_s;
    logic [7:0]      err_cnt_r;

    // Ready depends only on registered state: FIFO level plus the word held in S.
    always_comb begin
        occupancy_s = {1'b0, fifo_level_s} + {{LW{1'b0}}, s_vld_r};
        in_ready    = (occupancy_s < DEPTH_W) && !fifo_full_s;
        accept_s    = in_valid && in_ready;
        out_valid   = !fifo_empty_s;
        pop_s       = out_valid && out_ready;
    end

    register #(.WIDTH(SIZE + 1)) u_coded_reg (
        .clk   (clk),
        .res_n (res_n),
        .en    (accept_s),
        .d     (in_coded),
        .q     (coded_r)
    );

    register #(.WIDTH(SIZE)) u_gamma_reg (
        .clk   (clk),
        .res_n (res_n),
        .en    (accept_s),
        .d     (in_gamma),
        .q     (gamma_r)
    );

    // S is valid exactly in the cycle after an accept; the write then drains it.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s_vld_r <= 1'b0;
        end else begin
            s_vld_r <= accept_s;
        end
    end

    // Subtract gamma; borrow or overflow past SIZE bits marks the word inconsistent.
    always_comb begin
        diff_s          = {1'b0, coded_r} - {2'b00, gamma_r};
        wr_entry_s.data = diff_s[SIZE-1:0];
        wr_entry_s.err  = diff_s[SIZE+1] | diff_s[SIZE];
    end

    gamma_fifo #(
        .WIDTH (SIZE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (s_vld_r),
        .pop   (pop_s),
        .wdata (wr_entry_s),
        .rdata (rd_entry_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Count error words as they are written into the FIFO, saturating at the max.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            err_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= sat_inc8(err_cnt_r, s_vld_r & wr_entry_s.err);
        end
    end

    assign out_data = rd_entry_s.data;
    assign out_err  = rd_entry_s.err;
    assign level    = fifo_level_s;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_gen_gamma_decoder.sv
// Directed bench for gen_gamma_decoder (SIZE=8, DEPTH=4) with a queue-based
// reference model and hand-computed spot values.
module tb_gen_gamma_decoder;

    logic       clk = 1'b0;
    logic       res_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_coded;
    logic [7:0] in_gamma;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic [2:0] level;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [8:0] q[$];
    bit         m_svld;
    logic [8:0] m_s;
    int         m_errcnt;
    int         pops;

    always #5 clk = ~clk;

    gen_gamma_decoder #(.SIZE(8), .DEPTH(4)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coded  (in_coded),
        .in_gamma  (in_gamma),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .level     (level),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] expect_entry(input logic [8:0] c, input logic [7:0] g);
        int   d;
        logic e;
        d = int'(c) - int'(g);
        e = (d < 0) || (d > 255);
        return {e, d[7:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_svld   = 1'b0;
        m_s      = 9'd0;
        m_errcnt = 0;
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, step, update.
    task automatic cycle(input logic v, input logic [8:0] c, input logic [7:0] g,
                         input logic rdy, output bit acc);
        bit exp_ready;
        bit do_pop;
        logic [8:0] head;
        in_valid  = v;
        in_coded  = c;
        in_gamma  = g;
        out_ready = rdy;
        #1;
        exp_ready = (q.size() + int'(m_svld)) < 4;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            head = q[0];
            check("out_data", out_data, head[7:0]);
            check("out_err", out_err, head[8]);
        end
        acc    = v && exp_ready;
        do_pop = rdy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (do_pop) begin
            head = q.pop_front();
            pops++;
        end
        if (m_svld) begin
            q.push_back(m_s);
            if (m_s[8] && m_errcnt < 255) m_errcnt++;
        end
        m_svld = acc;
        if (acc) m_s = expect_entry(c, g);
        check("level", level, q.size());
        check("err_cnt", err_cnt, m_errcnt);
    endtask

    task automatic idle(input int n, input logic rdy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 9'd0, 8'd0, rdy, acc);
    endtask

    logic [8:0] bp_c [6];
    logic [7:0] bp_g [6];

    initial begin
        bit acc;
        int idx;
        int sel;
        int pops_base;

        res_n     = 1'b0;
        in_valid  = 1'b0;
        in_coded  = 9'd0;
        in_gamma  = 8'd0;
        out_ready = 1'b0;
        pops      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_err", out_err, 0);
        res_n = 1'b1;

        // Round trip: 0x11D - 0xC3 = 0x5A.
        cycle(1'b1, 9'h11D, 8'hC3, 1'b1, acc);
        cycle(1'b0, 9'h000, 8'h00, 1'b1, acc);
        check("rt_valid", out_valid, 1);
        check("rt_data", out_data, 8'h5A);
        check("rt_err", out_err, 0);
        check("rt_cnt", err_cnt, 0);
        idle(1, 1'b1);

        // Borrow: 0x010 - 0x20 wraps to 0xF0.
        cycle(1'b1, 9'h010, 8'h20, 1'b1, acc);
        cycle(1'b0, 9'h000, 8'h00, 1'b0, acc);
        check("brw_data", out_data, 8'hF0);
        check("brw_err", out_err, 1);
        check("brw_cnt", err_cnt, 1);

        // Overflow: 0x1FF - 0x00 exceeds 8 bits.
        cycle(1'b1, 9'h1FF, 8'h00, 1'b1, acc);
        cycle(1'b0, 9'h000, 8'h00, 1'b1, acc);
        check("ovf_data", out_data, 8'hFF);
        check("ovf_err", out_err, 1);
        check("ovf_cnt", err_cnt, 2);
        idle(2, 1'b1);

        // Backpressure: six offered with consumer stalled, exactly four taken.
        for (int i = 0; i < 6; i++) begin
            bp_c[i] = 9'(i * 17 + 40);
            bp_g[i] = 8'(i * 5);
        end
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, bp_c[idx], bp_g[idx], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_level", level, 4);
        check("bp_in_ready", in_ready, 0);
        pops_base = pops;
        for (int k = 0; k < 30 && !(idx == 6 && q.size() == 0 && !m_svld); k++) begin
            sel = (idx < 6) ? idx : 0;
            cycle(idx < 6, bp_c[sel], bp_g[sel], 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 6);
        check("bp_drained", pops - pops_base, 6);

        // Steady push/pop at level 2 (third word held in S).
        for (int k = 0; k < 3; k++) cycle(1'b1, 9'(k + 100), 8'(k), 1'b0, acc);
        check("pp_start_level", level, 2);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 1'b1, acc);
            check("pp_level", level, 2);
        end
        idle(5, 1'b1);
        check("pp_empty", out_valid, 0);

        // Saturation: 300 borrow words, counter stops at 255.
        for (int k = 0; k < 300; k++) cycle(1'b1, 9'h000, 8'h01, 1'b1, acc);
        idle(3, 1'b1);
        check("sat_cnt", err_cnt, 255);

        // Reset mid-stream with level 3 and S occupied.
        for (int k = 0; k < 4; k++) cycle(1'b1, 9'(k + 60), 8'(k + 1), 1'b0, acc);
        check("mid_level", level, 3);
        res_n = 1'b0;
        #2;
        check("mr_out_valid", out_valid, 0);
        check("mr_level", level, 0);
        check("mr_err_cnt", err_cnt, 0);
        check("mr_in_ready", in_ready, 1);
        model_reset();
        #2;
        res_n = 1'b1;
        cycle(1'b1, 9'h0A5, 8'h25, 1'b1, acc);
        cycle(1'b0, 9'h000, 8'h00, 1'b0, acc);
        check("mr_first_valid", out_valid, 1);
        check("mr_first_data", out_data, 8'h80);
        check("mr_first_err", out_err, 0);
        idle(2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_gamma_decoder.md
# gen_gamma_decoder

Receive-side counterpart of the gamma coder: accepts (SIZE+1)-bit coded words together with the SIZE-bit gamma they were coded with, and recovers the plain data by subtracting the gamma. One registered input stage feeds a subtractor, whose results go into a small output FIFO. Valid/ready handshakes on both sides. Sits directly downstream of the coder's `{carry, sum}` output register. Flags words whose coded value is inconsistent with the gamma, and keeps a saturating error count.

## Interface
- `SIZE`, 8, data and gamma width; coded word is SIZE+1 bits.
- `DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `res_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  coded word and gamma present.
- `in_ready`  out  1  block can accept this cycle.
- `in_coded`  in  SIZE+1  `{carry, sum}` from the coder.
- `in_gamma`  in  SIZE  gamma used for this word.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes the head this cycle.
- `out_data`  out  SIZE  recovered data.
- `out_err`  out  1  head word inconsistent.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err_cnt`  out  8  saturating count of error words written into the FIFO.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. The edge loads stage register S with coded and gamma, and sets `s_vld`.
- Subtract, combinational from S, width SIZE+2: `diff = {1'b0, coded} - {2'b0, gamma}`.
  - `out_data = diff[SIZE-1:0]`.
  - `err = diff[SIZE+1] | diff[SIZE]`. Bit SIZE+1 is the borrow (coded < gamma); bit SIZE is overflow (result ≥ 2^SIZE).
- Write: when `s_vld`, the next edge writes `{err, data}` into the FIFO and clears `s_vld`, unless a new accept reloads S on the same edge. There is no stall path from FIFO to S: the space check at accept guarantees the write.
- `in_ready = (level + s_vld) < DEPTH`.
  - Depends only on registered state; no combinational path from `out_ready` or `in_valid`.
  - A pop in the same cycle does not raise `in_ready` until the next cycle.
- Pop: `out_valid && out_ready` at an edge advances the read pointer.
  - Simultaneous write and pop: `level` unchanged, both pointers advance.
  - Pop when empty is ignored.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full: MSBs differ, low bits equal.
  - Empty: pointers equal.
- `out_valid = (level != 0)`. `out_data` and `out_err` come from the head entry; they are don't-care when `out_valid` is 0, and the bench must not check them then.
- `err_cnt` increments on each FIFO write with `err = 1` and saturates at 255.
- Reset (asynchronous, any time, including mid-stream): pointers 0, `level` 0, `s_vld` 0, `err_cnt` 0.
  - Therefore `in_ready = 1`, `out_valid = 0`, `out_err = 0`, `out_data` = 0.
  - Stage and FIFO data registers also clear to 0.
  - Words in flight are discarded.

## Timing
- Latency: accept at edge k; FIFO write at edge k+1; `out_valid` high in the cycle after edge k+1. This is two edges minimum.
- Throughput: one word per cycle while `level + s_vld < DEPTH` and the consumer pops every cycle.
- With `out_ready` held low, exactly DEPTH words are accepted, counting the one in S. `in_ready` drops in the cycle after the accept that makes `level + s_vld = DEPTH`.
- `level` and `err_cnt` update on the write or pop edge.

## Structure
- Package `gen_gamma_pkg`:
  - `localparam` `SIZE_DEFAULT` = 8.
  - Typedef for the FIFO entry `{logic err; logic [SIZE-1:0] data}`, parameterised through the module.
  - `ERR_CNT_MAX` = 255.
- Stage S reuses the existing `register` component: one instance for coded, one for gamma.
- One sub-module, `gamma_fifo`: a synchronous RAM-style FIFO parameterised by width and DEPTH, exposing `push`, `pop`, `full`, `empty` and `level`.
- The subtractor and error logic are inline in `gen_gamma_decoder`.

## Test plan
- Round trip: coded `9'h11D`, gamma `8'hC3`, `out_ready` = 1 → two edges later `out_valid` = 1, `out_data` = `8'h5A`, `out_err` = 0, `err_cnt` = 0.
- Borrow: coded `9'h010`, gamma `8'h20` → `out_data` = `8'hF0`, `out_err` = 1, `err_cnt` = 1.
  - Overflow: coded `9'h1FF`, gamma `8'h00` → `out_data` = `8'hFF`, `out_err` = 1, `err_cnt` = 2.
- Backpressure, DEPTH = 4: `out_ready` = 0, offer 6 words back-to-back → exactly 4 accepted, `in_ready` low with `level` = 4. Release `out_ready` → words drain in order, then the remaining 2 are accepted; no loss or duplication.
- Simultaneous push/pop at `level` = 2 for 20 cycles with random data → `level` stays 2, output sequence equals the input sequence delayed, pointers wrap correctly.
- Saturation: 300 error words → `err_cnt` stops at 255.
- Reset mid-stream: assert `res_n` low with `level` = 3 and `s_vld` = 1 → immediately `out_valid` = 0, `level` = 0, `err_cnt` = 0, `in_ready` = 1. After release, the first word accepted is the first word out.
